// File: rtl/network_tx_queued_pkg.sv
// Shared types and helpers for the queued network request path.
// The response-class enum is shared with the core's writeback demux.
package network_tx_queued_pkg;

  typedef enum logic [1:0] {
    e_tx_class_int_wb   = 2'd0,
    e_tx_class_float_wb = 2'd1,
    e_tx_class_ifetch   = 2'd2
  } tx_class_e;

  // Never returns 0, so that a single-entry parameter still yields a usable width.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/network_tx_queued_if.sv
// Request, issue, response and status signals of network_tx_queued.
// master = packet builder / endpoint side, slave = the queued transmitter.
interface network_tx_queued_if #(
  parameter int packet_width_p = 32,
  parameter int class_width_p  = 2,
  parameter int credit_width_p = 6,
  parameter int num_classes_p  = 3
) ();

  logic                                    req_v_i;
  logic [packet_width_p-1:0]               req_packet_i;
  logic [class_width_p-1:0]                req_class_i;
  logic                                    req_is_load_i;
  logic                                    req_illegal_i;
  logic                                    req_ready_o;
  logic [packet_width_p-1:0]               out_packet_o;
  logic                                    out_v_o;
  logic                                    out_credit_i;
  logic                                    resp_v_i;
  logic [class_width_p-1:0]                resp_class_i;
  logic [credit_width_p-1:0]               credits_o;
  logic [num_classes_p*credit_width_p-1:0] outstanding_o;
  logic                                    idle_o;
  logic                                    error_v_o;
  logic [packet_width_p-1:0]               error_packet_o;
  logic                                    error_clear_i;

  modport master (
    output req_v_i, req_packet_i, req_class_i, req_is_load_i, req_illegal_i,
           out_credit_i, resp_v_i, resp_class_i, error_clear_i,
    input  req_ready_o, out_packet_o, out_v_o, credits_o, outstanding_o,
           idle_o, error_v_o, error_packet_o
  );

  modport slave (
    input  req_v_i, req_packet_i, req_class_i, req_is_load_i, req_illegal_i,
           out_credit_i, resp_v_i, resp_class_i, error_clear_i,
    output req_ready_o, out_packet_o, out_v_o, credits_o, outstanding_o,
           idle_o, error_v_o, error_packet_o
  );

endinterface

// File: rtl/network_tx_queued_fifo.sv
// Small one-read one-write FIFO holding formed request entries.
// ready_o is simply "not full"; there is no bypass path.
module network_tx_queued_fifo
  import network_tx_queued_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp   = safe_clog2(els_p);
  localparam int count_width_lp = safe_clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_cnt_lp = count_width_lp'(els_p);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   rptr_r, wptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      enq, deq;

  assign ready_o = (count_r != full_cnt_lp);
  assign v_o     = (count_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r];

  // Pointers wrap explicitly so els_p need not be a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else begin
      if (enq) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + ptr_width_lp'(1);
      end
      if (deq) rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + ptr_width_lp'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + count_width_lp'(1);
        2'b01:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/network_tx_queued.sv
// Queued, credit-throttled request issue for the vanilla core's outgoing link.
// Tracks per-class outstanding loads, latches the first illegal request, reports idle.
module network_tx_queued
  import network_tx_queued_pkg::*;
#(
  parameter int packet_width_p    = 32,
  parameter int els_p             = 4,
  parameter int max_out_credits_p = 32,
  parameter int num_classes_p     = 3
) (
  input logic                clk_i,
  input logic                reset_i,
  network_tx_queued_if.slave bus
);

  localparam int class_width_lp  = safe_clog2(num_classes_p);
  localparam int credit_width_lp = safe_clog2(max_out_credits_p + 1);
  localparam int fifo_width_lp   = packet_width_p + class_width_lp + 1;
  localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);

  logic                                     fifo_ready, fifo_v, enq_v, illegal_v;
  logic                                     send, credits_full;
  logic [fifo_width_lp-1:0]                 fifo_wdata, fifo_rdata;
  logic [packet_width_p-1:0]                head_packet;
  logic [class_width_lp-1:0]                head_class;
  logic                                     head_is_load;
  logic [credit_width_lp-1:0]               credits_r;
  logic [num_classes_p-1:0]                 load_sent, resp_hit, resp_underflow;
  logic [num_classes_p*credit_width_lp-1:0] outstanding_flat;
  logic                                     error_v_r;
  logic [packet_width_p-1:0]                error_packet_r;

  assign enq_v      = bus.req_v_i & ~bus.req_illegal_i;
  assign illegal_v  = bus.req_v_i & fifo_ready & bus.req_illegal_i;
  assign fifo_wdata = {bus.req_packet_i, bus.req_class_i, bus.req_is_load_i};

  network_tx_queued_fifo #(
    .width_p (fifo_width_lp),
    .els_p   (els_p)
  ) req_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (enq_v),
    .data_i  (fifo_wdata),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (fifo_rdata),
    .yumi_i  (send)
  );

  assign {head_packet, head_class, head_is_load} = fifo_rdata;
  assign send         = fifo_v & (credits_r != '0);
  assign credits_full = (credits_r == credits_max_lp);

  // A credit return at the maximum is a protocol error; the count saturates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r <= credits_max_lp;
    end else if (send & ~bus.out_credit_i) begin
      credits_r <= credits_r - credit_width_lp'(1);
    end else if (~send & bus.out_credit_i & ~credits_full) begin
      credits_r <= credits_r + credit_width_lp'(1);
    end
  end

  for (genvar c = 0; c < num_classes_p; c++) begin : g_class
    logic [credit_width_lp-1:0] count_r;

    assign load_sent[c]      = send & head_is_load & (head_class == class_width_lp'(c));
    assign resp_hit[c]       = bus.resp_v_i & (bus.resp_class_i == class_width_lp'(c));
    assign resp_underflow[c] = resp_hit[c] & ~load_sent[c] & (count_r == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        count_r <= '0;
      end else if (load_sent[c] & ~resp_hit[c]) begin
        count_r <= count_r + credit_width_lp'(1);
      end else if (resp_hit[c] & ~load_sent[c] & (count_r != '0)) begin
        count_r <= count_r - credit_width_lp'(1);
      end
    end

    assign outstanding_flat[c*credit_width_lp +: credit_width_lp] = count_r;
  end

  // A same-cycle clear loses to a new illegal request, which is then captured.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_v_r      <= 1'b0;
      error_packet_r <= '0;
    end else if (illegal_v) begin
      error_v_r <= 1'b1;
      if (~error_v_r | bus.error_clear_i) error_packet_r <= bus.req_packet_i;
    end else if (bus.error_clear_i) begin
      error_v_r <= 1'b0;
    end
  end

  assign bus.req_ready_o    = fifo_ready;
  assign bus.out_v_o        = send;
  assign bus.out_packet_o   = head_packet;
  assign bus.credits_o      = credits_r;
  assign bus.outstanding_o  = outstanding_flat;
  assign bus.idle_o         = ~fifo_v & credits_full & (outstanding_flat == '0);
  assign bus.error_v_o      = error_v_r;
  assign bus.error_packet_o = error_packet_r;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.out_credit_i & ~send & credits_full));
  assert property (@(posedge clk_i) disable iff (reset_i)
    (resp_underflow == '0));
`endif

endmodule

// File: tb/tb_network_tx_queued.sv
// Scoreboard bench for network_tx_queued: instance A has 32 credits, instance B has 2.
// Sent packets are checked in order by a forked monitor; status outputs by directed checks.
module tb_network_tx_queued;
  import network_tx_queued_pkg::*;

  localparam int pw     = 16;
  localparam int els    = 4;
  localparam int ncls   = 3;
  localparam int cred_a = 32;
  localparam int cred_b = 2;
  localparam int cw     = safe_clog2(ncls);
  localparam int crw_a  = safe_clog2(cred_a + 1);
  localparam int crw_b  = safe_clog2(cred_b + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  network_tx_queued_if #(.packet_width_p(pw), .class_width_p(cw),
                         .credit_width_p(crw_a), .num_classes_p(ncls)) bus_a ();
  network_tx_queued_if #(.packet_width_p(pw), .class_width_p(cw),
                         .credit_width_p(crw_b), .num_classes_p(ncls)) bus_b ();

  network_tx_queued #(.packet_width_p(pw), .els_p(els), .max_out_credits_p(cred_a),
                      .num_classes_p(ncls)) dut_a (.clk_i(clk), .reset_i(rst), .bus(bus_a.slave));
  network_tx_queued #(.packet_width_p(pw), .els_p(els), .max_out_credits_p(cred_b),
                      .num_classes_p(ncls)) dut_b (.clk_i(clk), .reset_i(rst), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;
  int sends_a = 0;
  int sends_b = 0;
  logic [pw-1:0] exp_a[$];
  logic [pw-1:0] exp_b[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic v, input logic [pw-1:0] pkt,
                               input logic [cw-1:0] cls, input logic is_load, input logic illegal);
    if (sel == 0) begin
      bus_a.req_v_i = v; bus_a.req_packet_i = pkt; bus_a.req_class_i = cls;
      bus_a.req_is_load_i = is_load; bus_a.req_illegal_i = illegal;
    end else begin
      bus_b.req_v_i = v; bus_b.req_packet_i = pkt; bus_b.req_class_i = cls;
      bus_b.req_is_load_i = is_load; bus_b.req_illegal_i = illegal;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every observed send must match the oldest expected packet of that instance.
  task automatic monitorLoop();
    logic [pw-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus_a.out_v_o) begin
        sends_a++;
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL send_a_unexpected actual=%0h required=none", bus_a.out_packet_o);
        end else begin
          exp = exp_a.pop_front();
          checkOutput("send_a_packet", 32'(bus_a.out_packet_o), 32'(exp));
        end
      end
      if (!rst && bus_b.out_v_o) begin
        sends_b++;
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL send_b_unexpected actual=%0h required=none", bus_b.out_packet_o);
        end else begin
          exp = exp_b.pop_front();
          checkOutput("send_b_packet", 32'(bus_b.out_packet_o), 32'(exp));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 1'b0, 1'b0);
    bus_a.out_credit_i = 1'b0; bus_a.resp_v_i = 1'b0; bus_a.resp_class_i = '0; bus_a.error_clear_i = 1'b0;
    bus_b.out_credit_i = 1'b0; bus_b.resp_v_i = 1'b0; bus_b.resp_class_i = '0; bus_b.error_clear_i = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_a_ready",       32'(bus_a.req_ready_o),    32'd1);
    checkOutput("reset_a_out_v",       32'(bus_a.out_v_o),        32'd0);
    checkOutput("reset_a_credits",     32'(bus_a.credits_o),      32'd32);
    checkOutput("reset_a_outstanding", 32'(bus_a.outstanding_o),  32'd0);
    checkOutput("reset_a_idle",        32'(bus_a.idle_o),         32'd1);
    checkOutput("reset_a_error_v",     32'(bus_a.error_v_o),      32'd0);
    checkOutput("reset_a_error_pkt",   32'(bus_a.error_packet_o), 32'd0);
    checkOutput("reset_b_credits",     32'(bus_b.credits_o),      32'd2);

    // Instance B: five stores against two credits.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, pw'(16'h3000 + i), '0, 1'b0, 1'b0);
      exp_b.push_back(pw'(16'h3000 + i));
      tick();
    end
    applyStimulus(1, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("b_stall_sends",   32'(sends_b),             32'd2);
    checkOutput("b_stall_credits", 32'(bus_b.credits_o),     32'd0);
    checkOutput("b_stall_ready",   32'(bus_b.req_ready_o),   32'd1);
    checkOutput("b_stall_out_v",   32'(bus_b.out_v_o),       32'd0);
    tick();
    checkOutput("b_stall_hold",    32'(sends_b),             32'd2);
    bus_b.out_credit_i = 1'b1;
    tick();
    bus_b.out_credit_i = 1'b0;
    checkOutput("b_credit_out_v",   32'(bus_b.out_v_o),      32'd1);
    checkOutput("b_credit_credits", 32'(bus_b.credits_o),    32'd1);
    tick();
    checkOutput("b_one_send",       32'(sends_b),            32'd3);
    checkOutput("b_one_send_out_v", 32'(bus_b.out_v_o),      32'd0);

    // Instance B: fill to els entries with no credits, then free one slot.
    for (int i = 5; i < 7; i++) begin
      applyStimulus(1, 1'b1, pw'(16'h3000 + i), '0, 1'b0, 1'b0);
      exp_b.push_back(pw'(16'h3000 + i));
      tick();
    end
    applyStimulus(1, 1'b1, 16'h3007, '0, 1'b0, 1'b0);
    checkOutput("b_full_ready",      32'(bus_b.req_ready_o), 32'd0);
    tick();
    checkOutput("b_full_ready_hold", 32'(bus_b.req_ready_o), 32'd0);
    checkOutput("b_full_no_send",    32'(sends_b),           32'd3);
    applyStimulus(1, 1'b0, '0, '0, 1'b0, 1'b0);
    bus_b.out_credit_i = 1'b1;
    tick();
    bus_b.out_credit_i = 1'b0;
    checkOutput("b_full_send_out_v", 32'(bus_b.out_v_o),     32'd1);
    checkOutput("b_full_send_ready", 32'(bus_b.req_ready_o), 32'd0);
    tick();
    checkOutput("b_full_ready_rise", 32'(bus_b.req_ready_o), 32'd1);
    checkOutput("b_full_sends",      32'(sends_b),           32'd4);

    // Instance A: four back-to-back int_wb loads.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, pw'(16'h1000 + i), e_tx_class_int_wb, 1'b1, 1'b0);
      exp_a.push_back(pw'(16'h1000 + i));
      tick();
      if (i == 0) checkOutput("a_first_out_v", 32'(bus_a.out_v_o), 32'd1);
    end
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("a_burst_sends",   32'(sends_a),                       32'd4);
    checkOutput("a_burst_out_v",   32'(bus_a.out_v_o),                 32'd0);
    checkOutput("a_burst_credits", 32'(bus_a.credits_o),               32'd28);
    checkOutput("a_burst_out0",    32'(bus_a.outstanding_o[crw_a-1:0]), 32'd4);
    checkOutput("a_burst_idle",    32'(bus_a.idle_o),                  32'd0);

    // Instance A: float load sent in the same cycle as a float response.
    applyStimulus(0, 1'b1, 16'h2001, e_tx_class_float_wb, 1'b1, 1'b0);
    exp_a.push_back(16'h2001);
    tick();
    applyStimulus(0, 1'b1, 16'h2002, e_tx_class_float_wb, 1'b1, 1'b0);
    exp_a.push_back(16'h2002);
    tick();
    checkOutput("a_float_out1_pre", 32'(bus_a.outstanding_o[2*crw_a-1:crw_a]), 32'd1);
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    bus_a.resp_v_i = 1'b1; bus_a.resp_class_i = e_tx_class_float_wb;
    tick();
    bus_a.resp_v_i = 1'b0;
    checkOutput("a_float_out1_same", 32'(bus_a.outstanding_o[2*crw_a-1:crw_a]), 32'd1);
    checkOutput("a_float_credits",   32'(bus_a.credits_o),                       32'd26);

    // Instance A: return every response and credit.
    for (int k = 0; k < 6; k++) begin
      if (k == 5) checkOutput("a_drain_idle_early", 32'(bus_a.idle_o), 32'd0);
      bus_a.out_credit_i = 1'b1;
      bus_a.resp_v_i     = (k < 5);
      bus_a.resp_class_i = (k == 4) ? e_tx_class_float_wb : e_tx_class_int_wb;
      tick();
    end
    bus_a.out_credit_i = 1'b0; bus_a.resp_v_i = 1'b0;
    checkOutput("a_drain_credits",     32'(bus_a.credits_o),     32'd32);
    checkOutput("a_drain_outstanding", 32'(bus_a.outstanding_o), 32'd0);
    checkOutput("a_drain_idle",        32'(bus_a.idle_o),        32'd1);
    checkOutput("a_scoreboard_empty",  32'(exp_a.size()),        32'd0);

    // Instance A: illegal requests and the sticky capture.
    applyStimulus(0, 1'b1, 16'h000A, '0, 1'b0, 1'b1);
    tick();
    applyStimulus(0, 1'b1, 16'h000B, '0, 1'b0, 1'b1);
    tick();
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("a_err_v",      32'(bus_a.error_v_o),      32'd1);
    checkOutput("a_err_first",  32'(bus_a.error_packet_o), 32'h000A);
    checkOutput("a_err_idle",   32'(bus_a.idle_o),         32'd1);
    applyStimulus(0, 1'b1, 16'h000C, '0, 1'b0, 1'b1);
    bus_a.error_clear_i = 1'b1;
    tick();
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    bus_a.error_clear_i = 1'b0;
    checkOutput("a_err_clear_set_v",   32'(bus_a.error_v_o),      32'd1);
    checkOutput("a_err_clear_set_pkt", 32'(bus_a.error_packet_o), 32'h000C);
    bus_a.error_clear_i = 1'b1;
    tick();
    bus_a.error_clear_i = 1'b0;
    checkOutput("a_err_cleared", 32'(bus_a.error_v_o), 32'd0);

    // Asynchronous reset mid-operation on both instances.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, pw'(16'h4000 + i), e_tx_class_ifetch, 1'b1, 1'b0);
      exp_a.push_back(pw'(16'h4000 + i));
      tick();
    end
    applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("a_pre_rst_out2",    32'(bus_a.outstanding_o[3*crw_a-1:2*crw_a]), 32'd2);
    checkOutput("a_pre_rst_credits", 32'(bus_a.credits_o),                        32'd30);
    checkOutput("b_pre_rst_idle",    32'(bus_b.idle_o),                           32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_a_out_v",       32'(bus_a.out_v_o),        32'd0);
    checkOutput("rst_a_credits",     32'(bus_a.credits_o),      32'd32);
    checkOutput("rst_a_outstanding", 32'(bus_a.outstanding_o),  32'd0);
    checkOutput("rst_a_idle",        32'(bus_a.idle_o),         32'd1);
    checkOutput("rst_a_error_pkt",   32'(bus_a.error_packet_o), 32'd0);
    checkOutput("rst_b_credits",     32'(bus_b.credits_o),      32'd2);
    checkOutput("rst_b_ready",       32'(bus_b.req_ready_o),    32'd1);
    checkOutput("rst_b_idle",        32'(bus_b.idle_o),         32'd1);
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("post_rst_a_idle", 32'(bus_a.idle_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
